// File: rtl/rx_pkg.sv
// Shared constants and FSM state type for the serial packet receiver.
package rx_pkg;
    localparam int PKT_W = 136;
    localparam int CRC_W = 8;
    localparam logic [CRC_W-1:0] CRC_POLY = 8'h07;
    localparam logic [CRC_W-1:0] CRC_INIT = 8'h00;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} rx_state_t;
endpackage

// File: rtl/rx_crc8_serial.sv
// Bit-serial CRC-8 (poly 0x07, init 0x00, no final XOR); clr wins over en.
module rx_crc8_serial
    import rx_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             bit_in,
    output logic [CRC_W-1:0] crc
);
    logic fb;

    assign fb = crc[CRC_W-1] ^ bit_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc <= CRC_INIT;
        end else if (clr) begin
            crc <= CRC_INIT;
        end else if (en) begin
            crc <= {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
        end
    end
endmodule

// File: rtl/rx_receiver.sv
// UART-style packet receiver: start bit, PKT_W data bits MSB first, stop bit, CRC-8 check.
// Define RX_ERR_CNT_EN to add saturating CRC/framing error counters.
module rx_receiver
    import rx_pkg::*;
#(
    parameter int BIT_CYCLES = 5208
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_line,
    output logic [PKT_W-1:0] rx_packet,
    output logic             rx_valid,
    output logic             crc_ok,
    output logic             frame_err,
    output logic             rx_busy
`ifdef RX_ERR_CNT_EN
    ,
    output logic [7:0]       crc_err_cnt,
    output logic [7:0]       frm_err_cnt
`endif
);
    localparam int TMR_W = $clog2(BIT_CYCLES);
    localparam int CNT_W = $clog2(PKT_W + 1);
    localparam logic [TMR_W-1:0] HALF_LAST = TMR_W'(BIT_CYCLES / 2 - 1);
    localparam logic [TMR_W-1:0] BIT_LAST  = TMR_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(PKT_W - 1);

    rx_state_t        state;
    logic             sync1, s_line, s_prev;
    logic [TMR_W-1:0] timer;
    logic [CNT_W-1:0] bit_cnt;
    logic [PKT_W-1:0] shreg;
    logic             stop_bit;
    logic [CRC_W-1:0] crc;
    logic             fall, bit_hit, crc_clr, crc_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= 1'b1;
            s_line <= 1'b1;
            s_prev <= 1'b1;
        end else begin
            sync1  <= rx_line;
            s_line <= sync1;
            s_prev <= s_line;
        end
    end

    assign fall    = s_prev & ~s_line;
    assign bit_hit = (timer == BIT_LAST);
    assign crc_clr = (state == START) && (timer == HALF_LAST) && !s_line;
    assign crc_en  = (state == DATA) && bit_hit;

    rx_crc8_serial u_crc (
        .clk    (clk),
        .rst    (rst),
        .clr    (crc_clr),
        .en     (crc_en),
        .bit_in (s_line),
        .crc    (crc)
    );

    // After the half-bit START wait, a full-bit period lands every sample at mid-bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            timer     <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            stop_bit  <= 1'b1;
            rx_packet <= '0;
            rx_valid  <= 1'b0;
            crc_ok    <= 1'b0;
            frame_err <= 1'b0;
            rx_busy   <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (fall) begin
                        timer   <= '0;
                        rx_busy <= 1'b1;
                        state   <= START;
                    end
                end
                START: begin
                    if (timer == HALF_LAST) begin
                        if (s_line) begin
                            rx_busy <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            timer   <= '0;
                            bit_cnt <= '0;
                            state   <= DATA;
                        end
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                DATA: begin
                    if (bit_hit) begin
                        timer   <= '0;
                        shreg   <= {shreg[PKT_W-2:0], s_line};
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        if (bit_cnt == LAST_IDX) state <= STOP;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                STOP: begin
                    if (bit_hit) begin
                        timer    <= '0;
                        stop_bit <= s_line;
                        state    <= DONE;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                DONE: begin
                    rx_packet <= shreg;
                    rx_valid  <= 1'b1;
                    crc_ok    <= (crc == '0);
                    frame_err <= ~stop_bit;
                    rx_busy   <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RX_ERR_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_err_cnt <= '0;
            frm_err_cnt <= '0;
        end else if (state == DONE) begin
            if ((crc != '0) && (crc_err_cnt != 8'hFF)) crc_err_cnt <= crc_err_cnt + 8'd1;
            if (!stop_bit && (frm_err_cnt != 8'hFF)) frm_err_cnt <= frm_err_cnt + 8'd1;
        end
    end
`endif
endmodule

// File: tb/tb_rx_receiver.sv
// Bench for rx_receiver: directed and random frames checked against a polynomial-division model.
module tb_rx_receiver;
    import rx_pkg::*;

    localparam int BC = 16;
    localparam int PW = PKT_W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx_line = 1'b1;
    logic [PW-1:0] rx_packet;
    logic          rx_valid, crc_ok, frame_err, rx_busy;
`ifdef RX_ERR_CNT_EN
    logic [7:0]    crc_err_cnt, frm_err_cnt;
    logic [7:0]    h_ccnt = '0, h_fcnt = '0;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int n_valid = 0;

    logic [PW+1:0] exp_q[$];
    logic [PW-1:0] h_pkt = '0;
    logic          h_ok = 1'b0, h_ferr = 1'b0;

    rx_receiver #(.BIT_CYCLES(BC)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_line   (rx_line),
        .rx_packet (rx_packet),
        .rx_valid  (rx_valid),
        .crc_ok    (crc_ok),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
`ifdef RX_ERR_CNT_EN
        ,
        .crc_err_cnt (crc_err_cnt),
        .frm_err_cnt (frm_err_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Remainder of the packet polynomial divided by x^8 + x^2 + x + 1.
    function automatic logic [7:0] crc_rem(input logic [PW-1:0] m);
        logic [PW-1:0] r;
        r = m;
        for (int i = PW - 1; i >= 8; i--) begin
            if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
        end
        return r[7:0];
    endfunction

    task automatic chkw(input string nm, input logic [PW+1:0] act, input logic [PW+1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b want %0b", nm, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Scoreboard: each rx_valid consumes one expected frame; outputs must hold between frames.
    always @(negedge clk) begin
        logic [PW+1:0] e;
        if (rst) begin
            h_pkt = '0; h_ok = 1'b0; h_ferr = 1'b0;
`ifdef RX_ERR_CNT_EN
            h_ccnt = '0; h_fcnt = '0;
`endif
            chkw("reset_outputs", {rx_packet, crc_ok, frame_err}, '0);
            chk1("reset_valid_busy", rx_valid | rx_busy, 1'b0);
        end else begin
            if (rx_valid) begin
                n_valid++;
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_valid: got pulse want none");
                end else begin
                    e = exp_q.pop_front();
                    h_pkt = e[PW+1:2]; h_ok = e[1]; h_ferr = e[0];
`ifdef RX_ERR_CNT_EN
                    if (!h_ok && h_ccnt != 8'hFF) h_ccnt = h_ccnt + 8'd1;
                    if (h_ferr && h_fcnt != 8'hFF) h_fcnt = h_fcnt + 8'd1;
`endif
                end
            end
            chkw("frame_outputs", {rx_packet, crc_ok, frame_err}, {h_pkt, h_ok, h_ferr});
`ifdef RX_ERR_CNT_EN
            chkw("err_counters", (PW+2)'({crc_err_cnt, frm_err_cnt}), (PW+2)'({h_ccnt, h_fcnt}));
`endif
        end
    end

    task automatic drive_bit(input logic b);
        rx_line = b;
        repeat (BC) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic idle(input int n);
        rx_line = 1'b1;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // abort_at >= 0 resets the DUT in the middle of that data bit.
    task automatic send_frame(input logic [PW-1:0] pkt, input logic stop, input int abort_at);
        if (abort_at < 0) exp_q.push_back({pkt, crc_rem(pkt) == 8'h00, ~stop});
        drive_bit(1'b0);
        for (int i = 0; i < PW; i++) begin
            if (i == abort_at) begin
                rx_line = pkt[PW-1-i];
                repeat (BC / 2) begin
                    @(posedge clk); #1;
                end
                chk1("busy_mid_frame", rx_busy, 1'b1);
                rx_line = 1'b1;
                rst = 1'b1;
                repeat (3) begin
                    @(posedge clk); #1;
                end
                rst = 1'b0;
                return;
            end
            drive_bit(pkt[PW-1-i]);
        end
        drive_bit(stop);
    endtask

    initial begin
        #(10 * 95000);
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [PW-1:0] p, x8, poly;
        logic [127:0]  d;
        logic          stop;
        int            v0, bc_cnt;

        x8 = '0; x8[8] = 1'b1;
        poly = '0; poly[8:0] = 9'h107;
        chki("pin_rem_x8", int'(crc_rem(x8)), 8'h07);
        chki("pin_rem_poly", int'(crc_rem(poly)), 0);
        p = poly; p[100] = 1'b1;
        chk1("pin_rem_flip", crc_rem(p) != 8'h00, 1'b1);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(10);

        v0 = n_valid;
        send_frame('0, 1'b1, -1);
        idle(4);
        chki("t1_valid_count", n_valid - v0, 1);
        chkw("t1_packet", (PW+2)'(rx_packet), '0);
        chk1("t1_crc_ok", crc_ok, 1'b1);
        chk1("t1_frame_err", frame_err, 1'b0);
        chk1("t1_busy_low", rx_busy, 1'b0);

        send_frame('0, 1'b0, -1);
        chk1("stoplow_frame_err", frame_err, 1'b1);
        chk1("stoplow_crc_ok", crc_ok, 1'b1);
`ifdef RX_ERR_CNT_EN
        chki("stoplow_frm_cnt", int'(frm_err_cnt), 1);
        chki("stoplow_crc_cnt", int'(crc_err_cnt), 0);
`endif
        v0 = n_valid;
        rx_line = 1'b0;
        repeat (100) begin
            @(posedge clk); #1;
        end
        idle(40);
        chki("stuck_low_no_frame", n_valid - v0, 0);

        send_frame(poly, 1'b1, -1);
        idle(3);
        chk1("t2_bit8", rx_packet[8], 1'b1);
        chki("t2_crc_field", int'(rx_packet[7:0]), 8'h07);
        chk1("t2_crc_ok", crc_ok, 1'b1);

        p = poly; p[100] = 1'b1;
        send_frame(p, 1'b1, -1);
        idle(3);
        chk1("t3_bit100", rx_packet[100], 1'b1);
        chk1("t3_crc_ok", crc_ok, 1'b0);
        chk1("t3_frame_err", frame_err, 1'b0);

        v0 = n_valid;
        bc_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            rx_line = (c < 4) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (rx_busy) bc_cnt++;
            @(posedge clk); #1;
        end
        chki("glitch_no_valid", n_valid - v0, 0);
        chk1("glitch_busy_len", (bc_cnt >= 1) && (bc_cnt <= 9), 1'b1);

        v0 = n_valid;
        send_frame({$urandom, $urandom, $urandom, $urandom, 8'h5A}, 1'b1, 60);
        idle(30);
        chki("abort_no_valid", n_valid - v0, 0);
        d = {$urandom, $urandom, $urandom, $urandom};
        send_frame({d, crc_rem({d, 8'h00})}, 1'b1, -1);
        idle(5);
        chki("after_abort_one_valid", n_valid - v0, 1);
        chk1("after_abort_crc_ok", crc_ok, 1'b1);

        for (int k = 0; k < 10; k++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            p = ($urandom_range(0, 1) == 1) ? {d, crc_rem({d, 8'h00})} : {d, 8'($urandom)};
            stop = ($urandom_range(0, 3) != 0);
            send_frame(p, stop, -1);
            idle(stop ? $urandom_range(0, 20) : $urandom_range(2, 20));
        end

        for (int k = 0; k < 200 && exp_q.size() != 0; k++) begin
            @(posedge clk); #1;
        end
        chki("all_frames_received", exp_q.size(), 0);
        idle(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
